// File: rtl/player_projectile_if.sv
// Player projectile I/O bundle: fire/position/enemy inputs and projectile outputs.
// Latency: none, wires only.
// Backpressure: none; the signals are plain levels sampled once per frame.
interface player_projectile_if;
    logic       fire;
    logic       facing;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] enemy_x;
    logic [9:0] enemy_y;
    logic       enemy_dead;
    logic       proj_active;
    logic [9:0] proj_x;
    logic [9:0] proj_y;
    logic       enemy_hit_en;

    // Game-logic side: drives player/enemy state, observes the projectile
    modport master (
        output fire, facing, player_x, player_y, enemy_x, enemy_y, enemy_dead,
        input  proj_active, proj_x, proj_y, enemy_hit_en
    );

    // Projectile block side
    modport slave (
        input  fire, facing, player_x, player_y, enemy_x, enemy_y, enemy_dead,
        output proj_active, proj_x, proj_y, enemy_hit_en
    );
endinterface

// File: rtl/player_projectile.sv
// Single player projectile: launch, per-frame motion, enemy overlap and hit-level generation.
// Latency: updates one Clk after the registered frame edge (two Clk after frame_clk rises).
// Backpressure: none; fire is level-sampled in IDLE only, ignored elsewhere.
module player_projectile #(
    parameter int X_MAX           = 639,
    parameter int PROJ_SPEED      = 4,
    parameter int PROJ_HALF       = 4,
    parameter int ENEMY_HALF      = 16,
    parameter int HIT_FRAMES      = 120,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    player_projectile_if.slave   bus
);

    localparam int CNT_MAX = (HIT_FRAMES > COOLDOWN_FRAMES) ? HIT_FRAMES : COOLDOWN_FRAMES;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [10:0]      REACH     = 11'(PROJ_HALF + ENEMY_HALF);
    localparam logic [10:0]      SPEED11   = 11'(PROJ_SPEED);
    localparam logic [10:0]      XMAX11    = 11'(X_MAX);
    localparam logic [9:0]       SPEED10   = 10'(PROJ_SPEED);
    localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        CONTACT  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             dir, dir_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [9:0]       px_nxt, py_nxt;

    logic             frame_clk_delayed;
    logic             fe;

    logic [10:0]      px11, py11, ex11, ey11;
    logic [10:0]      dx, dy;
    logic             ovl;

    // Frame edge detector; fe is a one-Clk pulse and is suppressed while in reset
    always_ff @(posedge Clk) begin
        frame_clk_delayed <= frame_clk;
        if (Reset)
            fe <= 1'b0;
        else
            fe <= frame_clk & ~frame_clk_delayed;
    end

    // Bounding-box overlap on the current (pre-move) projectile position
    always_comb begin
        px11 = {1'b0, bus.proj_x};
        py11 = {1'b0, bus.proj_y};
        ex11 = {1'b0, bus.enemy_x};
        ey11 = {1'b0, bus.enemy_y};
        dx   = (px11 >= ex11) ? (px11 - ex11) : (ex11 - px11);
        dy   = (py11 >= ey11) ? (py11 - ey11) : (ey11 - py11);
        ovl  = (dx <= REACH) && (dy <= REACH);
    end

    // Next-state and next-datapath decode; everything holds unless fe is high
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        px_nxt    = bus.proj_x;
        py_nxt    = bus.proj_y;
        if (fe) begin
            case (state)
                IDLE: begin
                    if (bus.fire) begin
                        dir_nxt   = bus.facing;
                        px_nxt    = bus.player_x;
                        py_nxt    = bus.player_y;
                        state_nxt = FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (ovl && !bus.enemy_dead) begin
                        state_nxt = CONTACT;
                        cnt_nxt   = HIT_LOAD;
                    end else if (!dir && (({1'b0, bus.proj_x} + SPEED11) > XMAX11)) begin
                        state_nxt = COOLDOWN;
                        cnt_nxt   = COOL_LOAD;
                    end else if (dir && (bus.proj_x < SPEED10)) begin
                        state_nxt = COOLDOWN;
                        cnt_nxt   = COOL_LOAD;
                    end else if (!dir) begin
                        px_nxt = bus.proj_x + SPEED10;
                    end else begin
                        px_nxt = bus.proj_x - SPEED10;
                    end
                end
                CONTACT: begin
                    // Position stays locked to the contact point regardless of enemy motion
                    if (bus.enemy_dead || (cnt == '0)) begin
                        state_nxt = COOLDOWN;
                        cnt_nxt   = COOL_LOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (cnt == '0)
                        state_nxt = IDLE;
                    else
                        cnt_nxt = cnt - 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs (outputs decoded from the next state)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= IDLE;
            dir              <= 1'b0;
            cnt              <= '0;
            bus.proj_x       <= '0;
            bus.proj_y       <= '0;
            bus.proj_active  <= 1'b0;
            bus.enemy_hit_en <= 1'b0;
        end else begin
            state            <= state_nxt;
            dir              <= dir_nxt;
            cnt              <= cnt_nxt;
            bus.proj_x       <= px_nxt;
            bus.proj_y       <= py_nxt;
            bus.proj_active  <= (state_nxt == FLIGHT) || (state_nxt == CONTACT);
            bus.enemy_hit_en <= (state_nxt == CONTACT);
        end
    end

endmodule

// File: tb/tb_player_projectile.sv
// Directed bench for player_projectile: reset, hit, both screen edges, dead enemy, reset in contact.
// Latency: each frame() call leaves the DUT settled after one frame edge.
// Backpressure: not applicable.
module tb_player_projectile;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;

    int checks   = 0;
    int failures = 0;
    int hi;
    int cnt_bad;

    player_projectile_if bus();

    player_projectile dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame_clk pulse; returns at a falling Clk edge with the update settled
    task automatic frame();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic launch(input logic [9:0] px, input logic [9:0] py, input logic fac);
        bus.player_x = px;
        bus.player_y = py;
        bus.facing   = fac;
        bus.fire     = 1'b1;
        frame();
        bus.fire     = 1'b0;
    endtask

    initial begin
        Reset          = 1'b1;
        frame_clk      = 1'b0;
        bus.fire       = 1'b1;
        bus.facing     = 1'b0;
        bus.player_x   = 10'd100;
        bus.player_y   = 10'd240;
        bus.enemy_x    = 10'd200;
        bus.enemy_y    = 10'd240;
        bus.enemy_dead = 1'b0;

        // 1. Reset with fire high and frame_clk toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst_active", 32'(bus.proj_active), 0);
            check("rst_hit", 32'(bus.enemy_hit_en), 0);
            frame_clk = ~frame_clk;
        end
        check("rst_x", 32'(bus.proj_x), 0);
        check("rst_y", 32'(bus.proj_y), 0);
        @(negedge Clk);
        Reset     = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check("no_launch_without_fe", 32'(bus.proj_active), 0);

        // 2. Hit sequence: launch on first edge after reset
        frame();
        bus.fire = 1'b0;
        check("launch_active", 32'(bus.proj_active), 1);
        check("launch_x", 32'(bus.proj_x), 100);
        check("launch_y", 32'(bus.proj_y), 240);
        check("launch_hit", 32'(bus.enemy_hit_en), 0);
        for (int k = 2; k <= 21; k++) begin
            frame();
            check("flight_x", 32'(bus.proj_x), 32'(100 + 4 * (k - 1)));
            check("flight_nohit", 32'(bus.enemy_hit_en), 0);
        end
        frame();
        check("contact_hit", 32'(bus.enemy_hit_en), 1);
        check("contact_active", 32'(bus.proj_active), 1);
        check("contact_x", 32'(bus.proj_x), 180);
        hi = 1;
        for (int i = 0; i < 200; i++) begin
            frame();
            if (!bus.enemy_hit_en) break;
            hi++;
        end
        check("hit_frames", 32'(hi), 120);
        check("post_hit_active", 32'(bus.proj_active), 0);
        check("post_hit_x", 32'(bus.proj_x), 180);

        // Cooldown with fire held: no launch for 30 edges, launch on the 31st
        bus.fire     = 1'b1;
        bus.facing   = 1'b0;
        bus.player_x = 10'd630;
        bus.player_y = 10'd240;
        bus.enemy_x  = 10'd100;
        bus.enemy_y  = 10'd400;
        cnt_bad = 0;
        repeat (30) begin
            frame();
            if (bus.proj_active) cnt_bad++;
        end
        check("cooldown_no_launch", 32'(cnt_bad), 0);

        // 3. Right edge, fire kept high in flight (no relaunch)
        frame();
        check("right_launch_active", 32'(bus.proj_active), 1);
        check("right_x0", 32'(bus.proj_x), 630);
        frame();
        check("right_x1", 32'(bus.proj_x), 634);
        frame();
        check("right_x2", 32'(bus.proj_x), 638);
        frame();
        check("right_end_active", 32'(bus.proj_active), 0);
        check("right_end_hit", 32'(bus.enemy_hit_en), 0);
        check("right_end_x", 32'(bus.proj_x), 638);
        bus.fire = 1'b0;
        frames(30);

        // 4. Left edge
        launch(10'd10, 10'd240, 1'b1);
        check("left_x0", 32'(bus.proj_x), 10);
        frame();
        check("left_x1", 32'(bus.proj_x), 6);
        frame();
        check("left_x2", 32'(bus.proj_x), 2);
        frame();
        check("left_end_active", 32'(bus.proj_active), 0);
        check("left_end_x", 32'(bus.proj_x), 2);
        frames(30);

        // 5. Enemy dies mid-contact, then pass-through of a dead enemy
        bus.enemy_x = 10'd200;
        bus.enemy_y = 10'd240;
        launch(10'd100, 10'd240, 1'b0);
        frames(21);
        check("c5_contact", 32'(bus.enemy_hit_en), 1);
        frames(4);
        check("c5_still_contact", 32'(bus.enemy_hit_en), 1);
        bus.enemy_dead = 1'b1;
        frame();
        check("dead_hit_drop", 32'(bus.enemy_hit_en), 0);
        check("dead_active_drop", 32'(bus.proj_active), 0);
        bus.fire = 1'b1;
        cnt_bad = 0;
        repeat (30) begin
            frame();
            if (bus.proj_active) cnt_bad++;
        end
        check("dead_cooldown", 32'(cnt_bad), 0);
        frame();
        bus.fire = 1'b0;
        check("dead_relaunch_active", 32'(bus.proj_active), 1);
        check("dead_relaunch_x", 32'(bus.proj_x), 100);
        cnt_bad = 0;
        repeat (30) begin
            frame();
            if (bus.enemy_hit_en) cnt_bad++;
        end
        check("dead_pass_nohit", 32'(cnt_bad), 0);
        check("dead_pass_x", 32'(bus.proj_x), 220);
        check("dead_pass_active", 32'(bus.proj_active), 1);

        // 6. Reset mid-flight, then reset coincident with fe mid-contact
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        check("rst_flight_active", 32'(bus.proj_active), 0);
        bus.enemy_dead = 1'b0;
        launch(10'd100, 10'd240, 1'b0);
        frames(21);
        check("c6_contact", 32'(bus.enemy_hit_en), 1);
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        check("rst_fe_active", 32'(bus.proj_active), 0);
        check("rst_fe_hit", 32'(bus.enemy_hit_en), 0);
        check("rst_fe_x", 32'(bus.proj_x), 0);
        check("rst_fe_y", 32'(bus.proj_y), 0);
        Reset     = 1'b0;
        frame_clk = 1'b0;
        frame();
        check("idle_after_rst", 32'(bus.proj_active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_projectile.md
Name: player_projectile

Overview:
- Upstream of the enemy health tracker: owns the player's single projectile, moves it once per frame, detects overlap with the enemy bounding box, and drives the level `enemy_hit_en` that the health tracker samples.
- Runs on the system clock; advances only on a detected rising edge of `frame_clk` (~60 Hz).
- Its position outputs also feed the sprite/colour mapper.

Parameters:
- X_MAX, 639, rightmost valid pixel column.
- PROJ_SPEED, 4, pixels moved per frame.
- PROJ_HALF, 4, projectile half-size (square).
- ENEMY_HALF, 16, enemy bounding-box half-size (square).
- HIT_FRAMES, 120, frames `enemy_hit_en` is held per hit. Covers one full damage window of the health tracker.
- COOLDOWN_FRAMES, 30, frames after a projectile ends before the next launch is accepted.

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, synchronous active-high reset.
- frame_clk, input, 1, frame strobe (~60 Hz); rising edge detected internally.
- fire, input, 1, fire request level from the keyboard decoder.
- facing, input, 1, player direction: 0 = right, 1 = left.
- player_x, input, 10, player centre column.
- player_y, input, 10, player centre row.
- enemy_x, input, 10, enemy centre column.
- enemy_y, input, 10, enemy centre row.
- enemy_dead, input, 1, `dead` flag from the health tracker.
- proj_active, output, 1, projectile visible/in flight or in contact.
- proj_x, output, 10, projectile centre column.
- proj_y, output, 10, projectile centre row.
- enemy_hit_en, output, 1, enemy-overlap level to the health tracker.

Behaviour:

Frame-edge detection:
- Register `frame_clk` into `frame_clk_delayed`.
- `fe` = registered (`frame_clk` & !`frame_clk_delayed`). It is high for exactly one Clk cycle, one cycle after the sampled edge.
- All state, counter and position updates occur only on Clk cycles with `fe` = 1. Otherwise all registers hold.

Reset:
- state = IDLE; `proj_x` = `proj_y` = 0; dir = 0; frame counter = 0.
- `proj_active` = 0; `enemy_hit_en` = 0.
- Reset wins over `fe` in the same cycle. Reset mid-flight or mid-contact returns to IDLE immediately.

Outputs:
- All outputs are registered.
- `proj_active` = 1 iff state is FLIGHT or CONTACT.
- `enemy_hit_en` = 1 iff state is CONTACT.

Overlap test:
- `ovl` = (|`proj_x` − `enemy_x`| ≤ PROJ_HALF+ENEMY_HALF) & (|`proj_y` − `enemy_y`| ≤ PROJ_HALF+ENEMY_HALF).
- Differences are computed in 11-bit unsigned, subtracting smaller from larger. No wrap.

State machine (evaluated at `fe`):
- IDLE:
  - If `fire` = 1: latch dir = `facing`, `proj_x` = `player_x`, `proj_y` = `player_y`; go to FLIGHT.
  - Else stay. `fire` is level-sampled only here; fire in any other state is ignored.
- FLIGHT (checks in priority order):
  1. If `ovl` & !`enemy_dead`: go to CONTACT; position frozen; counter = HIT_FRAMES−1.
  2. Else if dir = 0 and `proj_x` + PROJ_SPEED > X_MAX: go to COOLDOWN; counter = COOLDOWN_FRAMES−1.
  3. Else if dir = 1 and `proj_x` < PROJ_SPEED: go to COOLDOWN; counter = COOLDOWN_FRAMES−1.
  4. Else `proj_x` ±= PROJ_SPEED; `proj_y` unchanged.
  - Overlap is checked against the pre-move position.
- CONTACT:
  - If `enemy_dead` = 1: go to COOLDOWN; counter = COOLDOWN_FRAMES−1.
  - Else if counter = 0: go to COOLDOWN; counter = COOLDOWN_FRAMES−1.
  - Else counter−1.
  - Enemy motion while in contact is ignored; the projectile stays locked for the full HIT_FRAMES.
- COOLDOWN:
  - If counter = 0: go to IDLE. Else counter−1.

Other rules:
- `enemy_dead` = 1 at launch: the projectile flies and never enters CONTACT.
- Counter width is $clog2(max(HIT_FRAMES, COOLDOWN_FRAMES)). Both frame parameters must be ≥ 1.

Test Plan:
1. Reset held 3 cycles with `fire` = 1 and `frame_clk` toggling -> state IDLE, `proj_active` = 0, `enemy_hit_en` = 0 throughout; first launch only on the first `fe` after Reset deasserts.
2. Hit sequence:
   - Stimulus: `player` = (100,240), `facing` = 0, `enemy` = (200,240), `fire` pulsed across one frame edge.
   - Required: `proj_x` = 100 after launch, +4 per frame; CONTACT entered on the 22nd frame edge counting launch as edge 1; `proj_x` frozen at 180.
   - Required: `enemy_hit_en` high for exactly 120 frames, then `proj_active` drops.
   - Required: after 30 further frame edges, state returns to IDLE.
3. Right edge: launch at `player_x` = 630, right, enemy at (100,400) -> `proj_x` 630, 634, 638; next edge goes to COOLDOWN with `proj_active` = 0, no hit.
4. Left edge: launch at `player_x` = 10, left -> `proj_x` 10, 6, 2; next edge (2 < 4) goes to COOLDOWN, no underflow.
5. `enemy_dead` asserted at CONTACT frame 5 -> `enemy_hit_en` falls after the next `fe`; COOLDOWN 30 frames. A re-launch through the same enemy with `enemy_dead` = 1 passes through without CONTACT.
6. Reset asserted mid-CONTACT with `fe` coincident -> next cycle IDLE, `enemy_hit_en` = 0, `proj_x` = `proj_y` = 0. `fire` held high during FLIGHT/COOLDOWN produces no relaunch until IDLE.
